// File: rtl/if_fetch_unit_if.sv
// if_fetch_unit_if: fetch-stage bus bundling imem access, hazard/redirect control and IF/ID outputs
interface if_fetch_unit_if #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
);
  logic [ADDR_W-1:0] imem_addr_o;
  logic [31:0]       imem_data_i;
  logic              stall_i;
  logic              jump_n_i;
  logic              branch_taken_i;
  logic [ADDR_W-1:0] branch_target_i;
  logic [ADDR_W-1:0] pc_o;
  logic [31:0]       if_id_instr_o;
  logic [ADDR_W-1:0] if_id_pc4_o;
  logic              if_id_valid_o;
  logic              flush_o;
  logic [CNT_W-1:0]  flush_cnt_o;
  modport master (
    output imem_addr_o, pc_o, if_id_instr_o, if_id_pc4_o, if_id_valid_o, flush_o, flush_cnt_o,
    input  imem_data_i, stall_i, jump_n_i, branch_taken_i, branch_target_i
  );
  modport slave (
    input  imem_addr_o, pc_o, if_id_instr_o, if_id_pc4_o, if_id_valid_o, flush_o, flush_cnt_o,
    output imem_data_i, stall_i, jump_n_i, branch_taken_i, branch_target_i
  );
endinterface

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: PC register, instruction fetch and IF/ID register with branch/jump/stall priority
module if_fetch_unit #(
  parameter int               ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [31:0]      NOP_INSTR = 32'h0000_0000,
  parameter int               CNT_W     = 16
) (
  input logic            clk_i,
  input logic            rst_i,
  if_fetch_unit_if.master bus
);
  typedef enum logic {BOOT, RUN} state_t;
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, pc4_q, pc4_d, pc_plus4, jump_tgt;
  logic [31:0]       instr_q, instr_d;
  logic              valid_q, valid_d, flush;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
  assign pc_plus4 = pc_q + ADDR_W'(4);
  assign jump_tgt = {pc4_q[ADDR_W-1:28], instr_q[25:0], 2'b00};
  assign cnt_inc  = &cnt_q ? cnt_q : cnt_q + CNT_W'(1);
  assign bus.imem_addr_o   = pc_q;
  assign bus.pc_o          = pc_q;
  assign bus.if_id_instr_o = instr_q;
  assign bus.if_id_pc4_o   = pc4_q;
  assign bus.if_id_valid_o = valid_q;
  assign bus.flush_o       = flush;
  assign bus.flush_cnt_o   = cnt_q;
  // next-state: boot hold, then branch > stall > jump > sequential fetch
  always_comb begin
    state_d = RUN;
    pc_d    = pc_q;
    pc4_d   = pc4_q;
    instr_d = instr_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    flush   = 1'b0;
    if (state_q == RUN) begin
      if (bus.branch_taken_i) begin
        pc_d    = bus.branch_target_i & ~ADDR_W'(3);
        instr_d = NOP_INSTR;
        valid_d = 1'b0;
        flush   = 1'b1;
        cnt_d   = cnt_inc;
      end else if (bus.stall_i) begin
        pc_d = pc_q;
      end else if (!bus.jump_n_i && valid_q) begin
        pc_d    = jump_tgt;
        instr_d = NOP_INSTR;
        valid_d = 1'b0;
        cnt_d   = cnt_inc;
      end else begin
        pc_d    = pc_plus4;
        pc4_d   = pc_plus4;
        instr_d = bus.imem_data_i;
        valid_d = 1'b1;
      end
    end
  end
  // state, PC and IF/ID registers with asynchronous reset
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      pc4_q   <= '0;
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pc4_q   <= pc4_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: directed stimulus with a behavioural fetch model and per-cycle comparison
module tb_if_fetch_unit;
  logic        clk = 0, rst = 1, stall = 0, jn = 1, br = 0, chk_en = 0;
  logic [31:0] bt = 0;
  int          tests = 0, fails = 0;
  always #5 clk = ~clk;

  if_fetch_unit_if #(.ADDR_W(32), .CNT_W(16)) bus ();
  if_fetch_unit_if #(.ADDR_W(32), .CNT_W(2))  bus2 ();

  if_fetch_unit #(.ADDR_W(32), .CNT_W(16)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));
  if_fetch_unit #(.ADDR_W(32), .CNT_W(2))  dut2 (.clk_i(clk), .rst_i(rst), .bus(bus2));

  logic [31:0] rom [16];
  initial begin
    foreach (rom[i]) rom[i] = 32'h0000_0000;
    rom[0] = 32'h2008_0005;
    rom[1] = 32'h0800_0010;
    rom[2] = 32'h2009_0001;
  end
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a < 32'd64) ? rom[a[5:2]] : (a ^ 32'h5A5A_0000);
  endfunction

  assign bus.imem_data_i      = mem_word(bus.imem_addr_o);
  assign bus.stall_i          = stall;
  assign bus.jump_n_i         = jn;
  assign bus.branch_taken_i   = br;
  assign bus.branch_target_i  = bt;
  assign bus2.imem_data_i     = mem_word(bus2.imem_addr_o);
  assign bus2.stall_i         = stall;
  assign bus2.jump_n_i        = jn;
  assign bus2.branch_taken_i  = br;
  assign bus2.branch_target_i = bt;

  // Behavioural model: one boot cycle, then the four-way priority rule
  logic [31:0] m_pc, m_instr, m_pc4;
  logic        m_valid, m_boot;
  int          m_cnt;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pc = 0; m_instr = 0; m_pc4 = 0; m_valid = 0; m_cnt = 0; m_boot = 1;
    end else if (m_boot) begin
      m_boot = 0;
    end else if (br) begin
      m_pc = {bt[31:2], 2'b00}; m_instr = 0; m_valid = 0; m_cnt++;
    end else if (stall) begin
      m_pc = m_pc;
    end else if (!jn && m_valid) begin
      m_pc = {m_pc4[31:28], m_instr[25:0], 2'b00}; m_instr = 0; m_valid = 0; m_cnt++;
    end else begin
      m_instr = mem_word(m_pc); m_pc = m_pc + 32'd4; m_pc4 = m_pc; m_valid = 1;
    end
  end

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  // Per-cycle comparison against the model, mid-cycle when inputs are stable
  always @(negedge clk) begin
    if (chk_en && !rst) begin
      chk("pc", bus.pc_o, m_pc);
      chk("imem_addr", bus.imem_addr_o, m_pc);
      chk("instr", bus.if_id_instr_o, m_instr);
      chk("pc4", bus.if_id_pc4_o, m_pc4);
      chk("valid", bus.if_id_valid_o, m_valid);
      chk("flush", bus.flush_o, br && !m_boot);
      chk("cnt", bus.flush_cnt_o, (m_cnt > 65535) ? 65535 : m_cnt);
      chk("cnt2", bus2.flush_cnt_o, (m_cnt > 3) ? 3 : m_cnt);
      chk("pc2", bus2.pc_o, m_pc);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    chk_en = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    chk("rst_pc", bus.pc_o, 32'h0);
    chk("rst_valid", bus.if_id_valid_o, 1'b0);
    br = 1; bt = 32'h300; #1;
    chk("boot_flush", bus.flush_o, 1'b0);
    tick(); br = 0;
    chk("boot_pc", bus.pc_o, 32'h0);
    chk("boot_valid", bus.if_id_valid_o, 1'b0);
    chk("boot_cnt", bus.flush_cnt_o, 16'h0);
    tick();
    chk("seq_pc4", bus.pc_o, 32'h4);
    chk("seq_opc", bus.if_id_instr_o[31:26], 6'd8);
    chk("seq_valid", bus.if_id_valid_o, 1'b1);
    tick(); chk("seq_pc8", bus.pc_o, 32'h8);
    tick(); chk("seq_pc12", bus.pc_o, 32'hC);
    rst = 1; #2 rst = 0;
    tick(); chk("boot2_pc", bus.pc_o, 32'h0);
    tick(); tick();
    chk("jmp_instr", bus.if_id_instr_o, 32'h0800_0010);
    chk("jmp_pc4", bus.if_id_pc4_o, 32'h8);
    jn = 0;
    tick();
    chk("jmp_pc", bus.pc_o, 32'h40);
    chk("jmp_bubble", bus.if_id_valid_o, 1'b0);
    chk("jmp_cnt", bus.flush_cnt_o, 16'd1);
    #3 rst = 1; #1;
    chk("async_pc", bus.pc_o, 32'h0);
    chk("async_valid", bus.if_id_valid_o, 1'b0);
    chk("async_cnt", bus.flush_cnt_o, 16'd0);
    #2 rst = 0; jn = 1;
    tick(); chk("boot3_pc", bus.pc_o, 32'h0);
    tick();
    chk("boot3_pc4", bus.pc_o, 32'h4);
    chk("boot3_instr", bus.if_id_instr_o, 32'h2008_0005);
    stall = 1; br = 1; bt = 32'h103; #1;
    chk("bst_flush", bus.flush_o, 1'b1);
    tick(); br = 0;
    chk("bst_pc", bus.pc_o, 32'h100);
    chk("bst_valid", bus.if_id_valid_o, 1'b0);
    chk("bst_cnt", bus.flush_cnt_o, 16'd1);
    tick(); chk("stall_hold", bus.pc_o, 32'h100);
    stall = 0; jn = 0;
    tick();
    chk("bub_jmp_ign", bus.pc_o, 32'h104);
    chk("bub_valid", bus.if_id_valid_o, 1'b1);
    br = 1; bt = 32'h200;
    tick(); br = 0; jn = 1;
    chk("coll_pc", bus.pc_o, 32'h200);
    chk("coll_cnt", bus.flush_cnt_o, 16'd2);
    tick(); stall = 1;
    tick(); stall = 0;
    chk("stall_pc", bus.pc_o, 32'h204);
    chk("stall_instr", bus.if_id_instr_o, 32'h5A5A_0200);
    br = 1; bt = 32'hFFFF_FFFF;
    tick(); br = 0;
    chk("wrap_pre", bus.pc_o, 32'hFFFF_FFFC);
    tick();
    chk("wrap_pc", bus.pc_o, 32'h0);
    chk("wrap_pc4", bus.if_id_pc4_o, 32'h0);
    br = 1; bt = 32'h8;
    tick(); br = 0;
    chk("sat_cnt16", bus.flush_cnt_o, 16'd4);
    chk("sat_cnt2", bus2.flush_cnt_o, 2'd3);
    tick(); tick();
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch stage of the pipelined CPU; the producer side of the main decoder's opcode interface.
- Holds the PC, addresses instruction memory and loads the IF/ID register whose instruction field feeds the decoder's 6-bit opcode input.
- Accepts the control the decoder emits back: active-low jump, plus taken-branch from the EX/MEM stage.
- Handles stall, flush, redirect priority and boot sequencing.

Parameters:
- ADDR_W, 32, PC and address width in bits.
- RESET_PC, 32'h0000_0000, PC value loaded at reset.
- NOP_INSTR, 32'h0000_0000, bubble instruction inserted into IF/ID on flush; opcode 0 with all-zero fields.
- CNT_W, 16, width of the flush event counter.

Ports:
- clk_i, input, 1, system clock; all state changes on the rising edge.
- rst_i, input, 1, asynchronous active-high reset.
- imem_addr_o, output, ADDR_W, instruction memory address; always equals pc_o.
- imem_data_i, input, 32, instruction word; combinational read of imem_addr_o.
- stall_i, input, 1, hazard-unit stall; holds PC and IF/ID.
- jump_n_i, input, 1, decoder jump control, active low (0 = jump in ID).
- branch_taken_i, input, 1, EX/MEM branch resolved taken.
- branch_target_i, input, ADDR_W, EX/MEM branch target.
- pc_o, output, ADDR_W, current PC.
- if_id_instr_o, output, 32, IF/ID instruction; bits [31:26] drive the decoder opcode.
- if_id_pc4_o, output, ADDR_W, IF/ID PC+4.
- if_id_valid_o, output, 1, IF/ID holds a real instruction (0 = bubble).
- flush_o, output, 1, combinational request to flush the ID/EX and EX/MEM registers.
- flush_cnt_o, output, CNT_W, count of redirects taken.

Behaviour:
- Reset values:
  - pc_o = RESET_PC
  - if_id_instr_o = NOP_INSTR
  - if_id_pc4_o = 0
  - if_id_valid_o = 0
  - flush_cnt_o = 0
  - state = BOOT
- Reset mid-operation forces these values immediately, regardless of the clock.
- State machine:
  - BOOT: lasts one cycle after reset release. PC is held, IF/ID stays as a bubble, and all inputs are ignored. Next state is RUN.
  - RUN: normal operation. There is no exit except reset.
- jump_tgt = {if_id_pc4_o[31:28], if_id_instr_o[25:0], 2'b00}. It is used only when if_id_valid_o = 1.
- Next-PC priority in RUN, highest first:
  1. branch_taken_i = 1 → PC ← {branch_target_i[ADDR_W-1:2], 2'b00}; IF/ID ← NOP_INSTR, valid = 0; flush_o = 1; flush_cnt_o increments. Overrides stall_i.
  2. stall_i = 1 → PC and all IF/ID fields hold. A jump in ID is not taken; it is re-presented after the stall.
  3. jump_n_i = 0 and if_id_valid_o = 1 → PC ← jump_tgt; IF/ID ← NOP_INSTR, valid = 0; flush_o = 0; flush_cnt_o increments.
  4. Otherwise (sequential) → PC ← PC+4; IF/ID ← {imem_data_i, PC+4}, valid = 1.
- Arithmetic: PC+4 is modulo 2^ADDR_W, so 32'hFFFF_FFFC wraps to 0. Low 2 bits of every redirect target are forced to 00.
- Latency:
  - An instruction fetched at cycle N appears on if_id_instr_o after edge N+1.
  - Branch redirect: the target instruction is fetched in the cycle after branch_taken_i and appears in IF/ID one cycle later.
  - Jump costs exactly one bubble cycle.
- flush_o is combinational: flush_o = branch_taken_i when state is RUN, else 0.
- flush_cnt_o saturates at all-ones and does not wrap.
- jump_n_i with if_id_valid_o = 0 (bubble) is ignored.
- Simultaneous branch_taken_i and jump_n_i = 0: branch wins; the jump instruction is flushed.

Test Plan:
- Reset/boot: assert rst_i mid-cycle with PC = 0x40 → pc_o = 0 immediately, valid = 0. After release, first edge holds PC = 0 (BOOT). Next edge → PC = 4 and IF/ID = mem[0], valid = 1.
- Sequential fetch: memory loaded with 0x20080005 at address 0 → if_id_instr_o[31:26] = 6'd8. PC steps 0, 4, 8, 12 on successive edges.
- Jump: IF/ID holds opcode 6'b000010 with target field 0x10, pc4 = 0x8, jump_n_i = 0 → next PC = 0x40, one bubble (valid = 0), flush_cnt_o = 1.
- Branch over stall: stall_i = 1 and branch_taken_i = 1 with target 0x103 → PC = 0x100, flush_o = 1, IF/ID bubble. Next cycle with stall_i = 1 alone → PC holds at 0x100.
- Branch vs jump collision: both asserted, branch target 0x200, jump target 0x80 → PC = 0x200, flush_cnt_o increments by exactly 1.
- Wrap and saturation: PC = 0xFFFF_FFFC sequential → PC = 0, if_id_pc4_o = 0. With CNT_W = 2, four redirects → flush_cnt_o = 3.
